// File: rtl/snake_pkg.sv
// Shared types for the snake game-logic stage: directions, FSM states, grid cell.
package snake_pkg;

  localparam int CELL_CW = 7;
  localparam int LEN_W   = 6;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_CHECK,
    S_DEAD
  } state_t;

  typedef struct packed {
    logic [CELL_CW-1:0] x;
    logic [CELL_CW-1:0] y;
  } cell_t;

  // The encoding places opposite directions at bitwise complements.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/snake_hit_cmp.sv
// Parallel compare of one cell against the first i_len entries of the segment array.
module snake_hit_cmp
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  cell_t [MAX_LEN-1:0] i_seg,
  input  logic  [LEN_W-1:0]   i_len,
  input  cell_t               i_cell,
  output logic                o_hit
);

  logic [MAX_LEN-1:0] w_match;

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_lane
    assign w_match[i] = (i_seg[i] == i_cell) && (LEN_W'(i) < i_len);
  end

  assign o_hit = |w_match;

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: advances the segment array one cell per game tick, detects food and
// collisions, answers renderer occupancy queries. Define SNAKE_WRAP_EN for wrap-around edges.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 80,
  parameter int GRID_H   = 60,
  parameter int CW       = CELL_CW,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int INIT_X   = 40,
  parameter int INIT_Y   = 30
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iTick,
  input  logic          iStart,
  input  logic [1:0]    iDir,
  input  logic          iDirValid,
  input  logic [CW-1:0] iFoodX,
  input  logic [CW-1:0] iFoodY,
  input  logic [CW-1:0] iQueryX,
  input  logic [CW-1:0] iQueryY,
  output logic          oHit,
  output logic [CW-1:0] oHeadX,
  output logic [CW-1:0] oHeadY,
  output logic [5:0]    oLength,
  output logic          oEat,
  output logic          oDead
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // One extra bit so that 0-1 and GRID-1+1 are both visibly off-grid.
  typedef logic [CW:0] ext_t;

  state_t                r_state, w_state_nx;
  dir_t                  r_dir, r_pend;
  cell_t [MAX_LEN-1:0]   r_seg;
  logic  [LEN_W-1:0]     r_len;
  ext_t                  r_nx, r_ny;
  logic                  r_col, r_grow, r_eat, r_hit;
  ext_t                  w_mx, w_my;
  cell_t                 w_next, w_query;
  logic                  w_wall, w_food, w_self, w_qhit;
  logic  [LEN_W-1:0]     w_self_len;

  function automatic cell_t init_cell(input int i);
    cell_t c = '0;
    if (i < INIT_LEN) begin
      c.x = CELL_CW'(INIT_X - i);
      c.y = CELL_CW'(INIT_Y);
    end
    return c;
  endfunction

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (iStart) w_state_nx = S_RUN;
      S_RUN:   if (iTick)  w_state_nx = S_STEP;
      S_STEP:  w_state_nx = S_CHECK;
      S_CHECK: w_state_nx = r_col ? S_DEAD : S_RUN;
      S_DEAD:  if (iStart) w_state_nx = S_RUN;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_mx = {1'b0, r_seg[0].x};
    w_my = {1'b0, r_seg[0].y};
    unique case (r_pend)
      DIR_UP:    w_my = w_my - ext_t'(1);
      DIR_DOWN:  w_my = w_my + ext_t'(1);
      DIR_LEFT:  w_mx = w_mx - ext_t'(1);
      default:   w_mx = w_mx + ext_t'(1);
    endcase
    if (WRAP) begin
      if (w_mx == '1)                  w_mx = ext_t'(GRID_W - 1);
      else if (w_mx == ext_t'(GRID_W)) w_mx = '0;
      if (w_my == '1)                  w_my = ext_t'(GRID_H - 1);
      else if (w_my == ext_t'(GRID_H)) w_my = '0;
    end
  end

  assign w_wall     = (r_nx >= ext_t'(GRID_W)) || (r_ny >= ext_t'(GRID_H));
  assign w_next     = '{x: r_nx[CW-1:0], y: r_ny[CW-1:0]};
  assign w_query    = '{x: iQueryX, y: iQueryY};
  assign w_food     = !w_wall && (w_next.x == iFoodX) && (w_next.y == iFoodY);
  // The tail vacates on a plain move but stays put when growing.
  assign w_self_len = w_food ? r_len : r_len - LEN_W'(1);

  snake_hit_cmp #(.MAX_LEN(MAX_LEN)) u_query_cmp (
    .i_seg (r_seg),
    .i_len (r_len),
    .i_cell(w_query),
    .o_hit (w_qhit)
  );

  snake_hit_cmp #(.MAX_LEN(MAX_LEN)) u_self_cmp (
    .i_seg (r_seg),
    .i_len (w_self_len),
    .i_cell(w_next),
    .o_hit (w_self)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < MAX_LEN; i++) r_seg[i] <= init_cell(i);
      r_len  <= LEN_W'(INIT_LEN);
      r_dir  <= DIR_RIGHT;
      r_pend <= DIR_RIGHT;
      r_nx   <= '0;
      r_ny   <= '0;
      r_col  <= 1'b0;
      r_grow <= 1'b0;
      r_eat  <= 1'b0;
      r_hit  <= 1'b0;
    end else begin
      r_hit <= w_qhit;
      r_eat <= 1'b0;
      if (iDirValid && (dir_t'(iDir) != reverse_dir(r_dir))) r_pend <= dir_t'(iDir);
      unique case (r_state)
        S_RUN: if (iTick) begin
          r_nx  <= w_mx;
          r_ny  <= w_my;
          r_dir <= r_pend;
        end
        S_STEP: begin
          r_col  <= w_wall | w_self;
          r_grow <= w_food;
        end
        S_CHECK: if (!r_col) begin
          for (int i = MAX_LEN - 1; i > 0; i--) r_seg[i] <= r_seg[i-1];
          r_seg[0] <= w_next;
          if (r_grow) begin
            r_eat <= 1'b1;
            if (r_len < LEN_W'(MAX_LEN)) r_len <= r_len + LEN_W'(1);
          end
        end
        S_DEAD: if (iStart) begin
          for (int i = 0; i < MAX_LEN; i++) r_seg[i] <= init_cell(i);
          r_len  <= LEN_W'(INIT_LEN);
          r_dir  <= DIR_RIGHT;
          r_pend <= DIR_RIGHT;
        end
        default: ;
      endcase
    end
  end

  assign oHit    = r_hit;
  assign oHeadX  = r_seg[0].x;
  assign oHeadY  = r_seg[0].y;
  assign oLength = r_len;
  assign oEat    = r_eat;
  assign oDead   = (r_state == S_DEAD);

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus a random walk checked against a queue model.
module tb_snake_body_engine;

  localparam int CW   = 7;
  localparam int MAXL = 32;
  localparam int GW   = 80;
  localparam int GH   = 60;

  logic          iCLK = 1'b0, iRST_N = 1'b0, iTick = 1'b0, iStart = 1'b0, iDirValid = 1'b0;
  logic [1:0]    iDir = 2'b01;
  logic [CW-1:0] iFoodX = '0, iFoodY = '0, iQueryX = '0, iQueryY = '0;
  logic          oHit, oEat, oDead;
  logic [CW-1:0] oHeadX, oHeadY;
  logic [5:0]    oLength;

  int errors = 0;
  int checks = 0;

  // Reference model: body as coordinate queues, head at index 0.
  int mx[$], my[$];
  int m_dir, m_pend, fx, fy;
  bit m_dead, m_eat;

  snake_body_engine dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iTick(iTick), .iStart(iStart), .iDir(iDir),
    .iDirValid(iDirValid), .iFoodX(iFoodX), .iFoodY(iFoodY), .iQueryX(iQueryX),
    .iQueryY(iQueryY), .oHit(oHit), .oHeadX(oHeadX), .oHeadY(oHeadY),
    .oLength(oLength), .oEat(oEat), .oDead(oDead)
  );

  always #5 iCLK = ~iCLK;

  task automatic model_init();
    mx.delete(); my.delete();
    for (int i = 0; i < 4; i++) begin mx.push_back(40 - i); my.push_back(30); end
    m_dir = 1; m_pend = 1; m_dead = 1'b0; m_eat = 1'b0;
  endtask

  function automatic bit m_occ(input int x, input int y);
    for (int i = 0; i < mx.size(); i++) if (mx[i] == x && my[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // dir codes: 3 up, 0 down, 2 left, 1 right; opposite of d is 3-d
  task automatic model_tick();
    int nx = mx[0];
    int ny = my[0];
    int lim;
    bit wall = 1'b0, hit = 1'b0;
    m_dir = m_pend;
    case (m_dir)
      3: ny = ny - 1;
      0: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
`ifdef SNAKE_WRAP_EN
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
`else
    wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`endif
    m_eat = !wall && nx == fx && ny == fy;
    lim = m_eat ? mx.size() : mx.size() - 1;
    for (int i = 0; i < lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1'b1;
    if (wall || hit) begin
      m_dead = 1'b1; m_eat = 1'b0;
    end else begin
      mx.push_front(nx); my.push_front(ny);
      if (!(m_eat && mx.size() <= MAXL)) begin void'(mx.pop_back()); void'(my.pop_back()); end
    end
  endtask

  task automatic set_food(input int x, input int y);
    @(negedge iCLK);
    fx = x; fy = y; iFoodX = CW'(x); iFoodY = CW'(y);
  endtask

  task automatic do_dir(input int d);
    @(negedge iCLK);
    iDir = 2'(d); iDirValid = 1'b1;
    @(negedge iCLK);
    iDirValid = 1'b0;
    if (d != 3 - m_dir) m_pend = d;
  endtask

  // Returns at the negedge just after the body update, where oEat is high for an eat.
  task automatic do_tick();
    model_tick();
    @(negedge iCLK) iTick = 1'b1;
    @(negedge iCLK) iTick = 1'b0;
    repeat (2) @(negedge iCLK);
  endtask

  task automatic do_start();
    @(negedge iCLK) iStart = 1'b1;
    @(negedge iCLK) iStart = 1'b0;
    model_init();
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    checks++;
    if ({oHit, oEat, oDead} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got hit/eat/dead=%b want 000", {oHit, oEat, oDead});
    end
    checks++;
    if ({oHeadX, oHeadY, oLength} !== {7'd40, 7'd30, 6'd4}) begin
      errors++; $display("FAIL reset_body got head=(%0d,%0d) len=%0d want (40,30) len=4", oHeadX, oHeadY, oLength);
    end
    iRST_N = 1'b1;
    model_init();
    set_food(0, 0);
  endtask

  task automatic test_query();
    int qx, qy;
    @(negedge iCLK) begin iQueryX = 7'd38; iQueryY = 7'd30; end
    @(negedge iCLK);
    checks++;
    if (oHit !== 1'b1) begin errors++; $display("FAIL query_38_30 got %b want 1", oHit); end
    iQueryX = 7'd36;
    @(negedge iCLK);
    checks++;
    if (oHit !== 1'b0) begin errors++; $display("FAIL query_36_30 got %b want 0", oHit); end
    for (int n = 0; n < 8; n++) begin
      qx = $urandom_range(34, 42); qy = $urandom_range(29, 31);
      iQueryX = CW'(qx); iQueryY = CW'(qy);
      @(negedge iCLK);
      checks++;
      if (oHit !== m_occ(qx, qy)) begin
        errors++; $display("FAIL query_rand (%0d,%0d) got %b want %b", qx, qy, oHit, m_occ(qx, qy));
      end
    end
  endtask

  task automatic test_run3();
    do_start();
    repeat (3) do_tick();
    checks++;
    if ({oHeadX, oHeadY, oLength, oDead} !== {7'd43, 7'd30, 6'd4, 1'b0}) begin
      errors++; $display("FAIL run3 got head=(%0d,%0d) len=%0d dead=%b want (43,30) len=4 dead=0", oHeadX, oHeadY, oLength, oDead);
    end
  endtask

  task automatic test_reverse();
    do_dir(1);
    do_dir(2);
    do_tick();
    checks++;
    if ({oHeadX, oHeadY} !== {7'd44, 7'd30}) begin
      errors++; $display("FAIL reverse_ignored got (%0d,%0d) want (44,30)", oHeadX, oHeadY);
    end
  endtask

  task automatic test_eat();
    set_food(45, 30);
    do_tick();
    checks++;
    if ({oEat, oLength} !== {1'b1, 6'd5}) begin
      errors++; $display("FAIL eat_pulse got eat=%b len=%0d want eat=1 len=5", oEat, oLength);
    end
    iQueryX = 7'd41; iQueryY = 7'd30;
    @(negedge iCLK);
    checks++;
    if (oEat !== 1'b0) begin errors++; $display("FAIL eat_one_cycle got %b want 0", oEat); end
    @(negedge iCLK);
    checks++;
    if (oHit !== 1'b1) begin errors++; $display("FAIL eat_tail_hit got %b want 1", oHit); end
    set_food(0, 0);
  endtask

  task automatic test_self();
    do_dir(3); do_tick();
    do_dir(2); do_tick();
    do_dir(0); do_tick();
    checks++;
    if ({oDead, oHeadX, oHeadY, oLength} !== {1'b1, 7'd44, 7'd29, 6'd5} || !m_dead) begin
      errors++; $display("FAIL self_kill got dead=%b head=(%0d,%0d) len=%0d want dead=1 (44,29) len=5", oDead, oHeadX, oHeadY, oLength);
    end
    @(negedge iCLK) iTick = 1'b1;
    @(negedge iCLK) iTick = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++;
    if ({oDead, oHeadX, oHeadY} !== {1'b1, 7'd44, 7'd29}) begin
      errors++; $display("FAIL dead_tick_dropped got dead=%b head=(%0d,%0d) want dead=1 (44,29)", oDead, oHeadX, oHeadY);
    end
    do_start();
    @(negedge iCLK);
    checks++;
    if ({oDead, oHeadX, oHeadY, oLength} !== {1'b0, 7'd40, 7'd30, 6'd4}) begin
      errors++; $display("FAIL restart got dead=%b head=(%0d,%0d) len=%0d want 0 (40,30) 4", oDead, oHeadX, oHeadY, oLength);
    end
  endtask

  task automatic test_wall();
    repeat (39) do_tick();
    checks++;
    if ({oHeadX, oHeadY} !== {7'd79, 7'd30}) begin
      errors++; $display("FAIL wall_approach got (%0d,%0d) want (79,30)", oHeadX, oHeadY);
    end
    do_tick();
    checks++;
    if ({oDead, oHeadX, oHeadY} !== {m_dead, 7'(mx[0]), 7'(my[0])}) begin
      errors++; $display("FAIL wall_edge got dead=%b head=(%0d,%0d) want dead=%b (%0d,%0d)", oDead, oHeadX, oHeadY, m_dead, mx[0], my[0]);
    end
    if (m_dead) do_start();
  endtask

  task automatic test_random_walk();
    int nx, ny, qx, qy, k;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0) do_dir($urandom_range(0, 3));
      nx = mx[0] + (m_pend == 1) - (m_pend == 2);
      ny = my[0] + (m_pend == 0) - (m_pend == 3);
      if ($urandom_range(0, 2) == 0 && nx >= 0 && nx < GW && ny >= 0 && ny < GH) set_food(nx, ny);
      else set_food($urandom_range(0, GW - 1), $urandom_range(0, GH - 1));
      do_tick();
      checks++;
      if ({oHeadX, oHeadY, oLength, oDead, oEat} !== {7'(mx[0]), 7'(my[0]), 6'(mx.size()), m_dead, m_eat}) begin
        errors++; $display("FAIL walk_step%0d got (%0d,%0d) len=%0d dead=%b eat=%b want (%0d,%0d) len=%0d dead=%b eat=%b",
          n, oHeadX, oHeadY, oLength, oDead, oEat, mx[0], my[0], mx.size(), m_dead, m_eat);
      end
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, mx.size() - 1); qx = mx[k]; qy = my[k];
      end else begin
        qx = $urandom_range(0, GW - 1); qy = $urandom_range(0, GH - 1);
      end
      iQueryX = CW'(qx); iQueryY = CW'(qy);
      @(negedge iCLK);
      checks++;
      if ({oHit, oEat} !== {m_occ(qx, qy), 1'b0}) begin
        errors++; $display("FAIL walk_query%0d (%0d,%0d) got hit=%b eat=%b want hit=%b eat=0", n, qx, qy, oHit, oEat, m_occ(qx, qy));
      end
      if (m_dead) do_start();
    end
  endtask

  task automatic test_reset_mid();
    iRST_N = 1'b0;
    @(negedge iCLK) iRST_N = 1'b1;
    model_init();
    set_food(41, 30);
    do_start();
    do_tick();
    set_food(0, 0);
    iQueryX = 7'd41; iQueryY = 7'd30;
    @(negedge iCLK);
    checks++;
    if ({oHit, oLength, oHeadX} !== {1'b1, 6'd5, 7'd41}) begin
      errors++; $display("FAIL mid_pre got hit=%b len=%0d x=%0d want hit=1 len=5 x=41", oHit, oLength, oHeadX);
    end
    @(negedge iCLK) iTick = 1'b1;
    @(negedge iCLK) iTick = 1'b0;
    @(negedge iCLK);
    #1 iRST_N = 1'b0;
    #1;
    checks++;
    if ({oHit, oEat, oDead, oHeadX, oHeadY, oLength} !== {3'b000, 7'd40, 7'd30, 6'd4}) begin
      errors++; $display("FAIL mid_check_reset got hit/eat/dead=%b head=(%0d,%0d) len=%0d want 000 (40,30) 4",
        {oHit, oEat, oDead}, oHeadX, oHeadY, oLength);
    end
    @(negedge iCLK) iRST_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_query();
    test_run3();
    test_reverse();
    test_eat();
    test_self();
    test_wall();
    test_random_walk();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
